// File: rtl/ysyx_041514_ifu_fetch_pkg.sv
// Shared sysconfig definitions for the fetch unit: FSM encodings, fetch mask and buffer entry layout.
package ysyx_041514_ifu_fetch_pkg;

  typedef enum logic [1:0] {
    F_RST  = 2'd0,
    F_IDLE = 2'd1,
    F_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [7:0] FETCH_RMASK = 8'h0F;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_041514_ifu_fifo.sv
// Instruction buffer: same-edge push/pop/flush, head visible the cycle after push.
// Caller never pushes when full or pops when empty; flush overrides push and pop.
module ysyx_041514_ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             head_vld_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_vld_o = (cnt_q != '0);
  assign full_o     = (cnt_q == DEPTH[AW:0]);
  assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ysyx_041514_ifu_fetch.sv
// Fetch FSM: one outstanding icache request, responses buffered for decode; <=1 fetch per 2 cycles.
// Stalls issue while the buffer is full or fence.i is active; YSYX_041514_IFU_PERF_EN adds perf counters.
module ysyx_041514_ifu_fetch
  import ysyx_041514_ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] preif_raddr_o,
  output logic [7:0]  preif_rmask_o,
  output logic        preif_raddr_valid_o,
  input  logic [63:0] if_rdata_i,
  input  logic        if_rdata_valid_i,
  input  logic        fencei_valid_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  output logic        id_valid_o,
  input  logic        id_ready_i
`ifdef YSYX_041514_IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt_o,
  output logic [63:0] perf_stall_cnt_o
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         kill_q;
  logic [31:0]  raddr_q;
  logic         raddr_vld_q;

  logic         push_d;
  logic         pop_d;
  logic         fifo_full;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic         unused_rdata_hi;

  // A redirect landing on the response edge drops that response instead of arming kill.
  assign push_d     = (state_q == F_WAIT) && if_rdata_valid_i && !kill_q && !redirect_valid_i;
  assign pop_d      = id_valid_o && id_ready_i;
  assign push_entry = '{pc: pc_q, inst: if_rdata_i[31:0]};
  assign unused_rdata_hi = ^if_rdata_i[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= F_RST;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      raddr_q     <= '0;
      raddr_vld_q <= 1'b0;
    end else begin
      if (redirect_valid_i) pc_q <= {redirect_pc_i[31:2], 2'b00};
      else if (push_d)      pc_q <= pc_q + 32'd4;

      case (state_q)
        F_RST: state_q <= F_IDLE;
        F_IDLE: begin
          if (!redirect_valid_i && !fencei_valid_i && !fifo_full) begin
            state_q     <= F_WAIT;
            raddr_q     <= pc_q;
            raddr_vld_q <= 1'b1;
          end
        end
        F_WAIT: begin
          if (if_rdata_valid_i) begin
            state_q     <= F_IDLE;
            raddr_vld_q <= 1'b0;
            kill_q      <= 1'b0;
          end else if (redirect_valid_i) begin
            kill_q <= 1'b1;
          end
        end
        default: state_q <= F_RST;
      endcase
    end
  end

  ysyx_041514_ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect_valid_i),
    .push_i     (push_d),
    .push_dat_i (push_entry),
    .pop_i      (pop_d),
    .head_dat_o (head_entry),
    .head_vld_o (id_valid_o),
    .full_o     (fifo_full)
  );

  assign preif_raddr_o       = raddr_q;
  assign preif_raddr_valid_o = raddr_vld_q;
  assign preif_rmask_o       = FETCH_RMASK;
  assign id_inst_o           = head_entry.inst;
  assign id_pc_o             = head_entry.pc;

`ifdef YSYX_041514_IFU_PERF_EN
  logic [63:0] fetch_cnt_q;
  logic [63:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push_d)             fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (state_q == F_WAIT)  stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_041514_ifu_fetch.sv
// Directed bench for the fetch unit with a latency-programmable icache responder.
module tb_ysyx_041514_ifu_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] preif_raddr_o;
  logic [7:0]  preif_rmask_o;
  logic        preif_raddr_valid_o;
  logic [63:0] if_rdata_i;
  logic        if_rdata_valid_i;
  logic        fencei_valid_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic        id_valid_o;
  logic        id_ready_i;
`ifdef YSYX_041514_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt_o;
  logic [63:0] perf_stall_cnt_o;
`endif

  int n_total = 0;
  int n_pass  = 0;

  int   lat     = 0;
  bit   resp_en = 1'b1;
  int   cnt     = 0;
  logic model_vld = 1'b0;
  logic man_vld   = 1'b0;
  logic flag;

  ysyx_041514_ifu_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .preif_raddr_o       (preif_raddr_o),
    .preif_rmask_o       (preif_rmask_o),
    .preif_raddr_valid_o (preif_raddr_valid_o),
    .if_rdata_i          (if_rdata_i),
    .if_rdata_valid_i    (if_rdata_valid_i),
    .fencei_valid_i      (fencei_valid_i),
    .redirect_valid_i    (redirect_valid_i),
    .redirect_pc_i       (redirect_pc_i),
    .id_inst_o           (id_inst_o),
    .id_pc_o             (id_pc_o),
    .id_valid_o          (id_valid_o),
    .id_ready_i          (id_ready_i)
`ifdef YSYX_041514_IFU_PERF_EN
    ,
    .perf_fetch_cnt_o    (perf_fetch_cnt_o),
    .perf_stall_cnt_o    (perf_stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign if_rdata_i       = {32'hDEAD_BEEF, inst_of(preif_raddr_o)};
  assign if_rdata_valid_i = model_vld | man_vld;

  // Icache: one pulse per request, after lat extra cycles of the request being visible.
  always @(posedge clk) begin
    #2;
    if (rst || !preif_raddr_valid_o) begin
      model_vld = 1'b0;
      cnt = 0;
    end else if (model_vld) begin
      model_vld = 1'b0;
      cnt = 0;
    end else if (resp_en && cnt >= lat) begin
      model_vld = 1'b1;
    end else begin
      cnt = cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    while (preif_raddr_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    chk({tag, "_req_timeout"}, 64'(n < 40), 64'd1);
    chk({tag, "_addr"}, 64'(preif_raddr_o), 64'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (preif_raddr_valid_o !== 1'b0 && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    chk({tag, "_resp_timeout"}, 64'(n < 40), 64'd1);
  endtask

  task automatic fetch_one(input logic [31:0] exp, input string tag);
    wait_req(exp, tag);
    wait_idle(tag);
    chk({tag, "_id_valid"}, 64'(id_valid_o), 64'd1);
    chk({tag, "_id_pc"}, 64'(id_pc_o), 64'(exp));
    chk({tag, "_id_inst"}, 64'(id_inst_o), 64'(inst_of(exp)));
  endtask

  initial begin
    rst = 1'b1;
    fencei_valid_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = 32'h0;
    id_ready_i = 1'b0;
    step(3);
    chk("rst_raddr", 64'(preif_raddr_o), 64'h0);
    chk("rst_raddr_vld", 64'(preif_raddr_valid_o), 64'h0);
    chk("rst_id_valid", 64'(id_valid_o), 64'h0);
    chk("rst_id_inst", 64'(id_inst_o), 64'h0);
    chk("rst_id_pc", 64'(id_pc_o), 64'h0);
    chk("rmask", 64'(preif_rmask_o), 64'h0F);
`ifdef YSYX_041514_IFU_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt_o, 64'h0);
    chk("rst_perf_stall", perf_stall_cnt_o, 64'h0);
`endif

    // Release reset; F_RST holds for one cycle before fetching starts.
    rst = 1'b0;
    step(1);
    chk("frst_no_req", 64'(preif_raddr_valid_o), 64'h0);
    fetch_one(32'h8000_0000, "first");
    wait_req(32'h8000_0004, "second");
    wait_idle("second");
    chk("fill2_head_pc", 64'(id_pc_o), 64'h8000_0000);

    // Decode stalled: buffer full, no further requests.
    flag = 1'b0;
    repeat (18) begin
      step(1);
      flag = flag | preif_raddr_valid_o;
    end
    chk("full_no_req", 64'(flag), 64'h0);
    chk("full_head_pc", 64'(id_pc_o), 64'h8000_0000);
    chk("full_head_inst", 64'(id_inst_o), 64'(inst_of(32'h8000_0000)));

    id_ready_i = 1'b1;
    step(1);
    chk("pop1_pc", 64'(id_pc_o), 64'h8000_0004);
    chk("pop1_inst", 64'(id_inst_o), 64'(inst_of(32'h8000_0004)));
    step(1);
    chk("pop2_empty", 64'(id_valid_o), 64'h0);
    chk("refill_req_vld", 64'(preif_raddr_valid_o), 64'h1);
    chk("refill_req_addr", 64'(preif_raddr_o), 64'h8000_0008);
    wait_idle("pc8");
    chk("pc8_id_pc", 64'(id_pc_o), 64'h8000_0008);
    fetch_one(32'h8000_000C, "pcC");

    // Redirect during an 8-beat miss; 0xC stays buffered until the flush.
    id_ready_i = 1'b0;
    lat = 7;
    wait_req(32'h8000_0010, "miss");
    chk("miss_buf_valid", 64'(id_valid_o), 64'h1);
    step(2);
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h8000_1002;
    step(1);
    redirect_valid_i = 1'b0;
    chk("redir_flush", 64'(id_valid_o), 64'h0);
    chk("redir_req_held", 64'(preif_raddr_valid_o), 64'h1);
    chk("redir_addr_held", 64'(preif_raddr_o), 64'h8000_0010);
    wait_idle("killed");
    chk("killed_no_push", 64'(id_valid_o), 64'h0);
    lat = 0;
    id_ready_i = 1'b1;
    fetch_one(32'h8000_1000, "redir_target");

    // Redirect on the same edge as the response.
    resp_en = 1'b0;
    wait_req(32'h8000_1004, "coinc");
    man_vld = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h8000_2000;
    step(1);
    man_vld = 1'b0;
    redirect_valid_i = 1'b0;
    chk("coinc_no_push", 64'(id_valid_o), 64'h0);
    chk("coinc_idle", 64'(preif_raddr_valid_o), 64'h0);
    resp_en = 1'b1;
    fetch_one(32'h8000_2000, "coinc_target");

    // fence.i held in F_IDLE blocks new requests.
    fencei_valid_i = 1'b1;
    flag = 1'b0;
    repeat (5) begin
      step(1);
      flag = flag | preif_raddr_valid_o;
    end
    fencei_valid_i = 1'b0;
    chk("fencei_no_req", 64'(flag), 64'h0);
    fetch_one(32'h8000_2004, "post_fencei");

    // Reset while a miss is outstanding.
    id_ready_i = 1'b0;
    lat = 7;
    wait_req(32'h8000_2008, "rst_miss");
    chk("rst_miss_buf", 64'(id_valid_o), 64'h1);
    step(1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_vld", 64'(preif_raddr_valid_o), 64'h0);
    chk("mid_rst_raddr", 64'(preif_raddr_o), 64'h0);
    chk("mid_rst_id_valid", 64'(id_valid_o), 64'h0);
    chk("mid_rst_id_pc", 64'(id_pc_o), 64'h0);
    chk("mid_rst_id_inst", 64'(id_inst_o), 64'h0);
    rst = 1'b0;
    lat = 0;
    id_ready_i = 1'b1;
    fetch_one(32'h8000_0000, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
